// File: rtl/data_bus_if_pkg.sv
// Shared constants for the data-side bus master: reset/enable levels,
// stall-vector width and the 2-bit bus FSM encodings.
package data_bus_if_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;

    localparam int StallBus = 6;

    localparam logic [1:0] BUS_IDLE           = 2'b00;
    localparam logic [1:0] BUS_BUSY           = 2'b01;
    localparam logic [1:0] BUS_WAIT_FOR_STALL = 2'b10;

endpackage

// File: rtl/data_bus_if.sv
// Turns the memory stage's single-cycle RAM request into a Wishbone classic
// cycle, stalling the pipeline until ack and holding load data until release.
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [StallBus-1:0] stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [3:0]          cpu_sel_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                stallreq_o,
    output logic                bus_err_o,
    output logic [31:0]         wb_adr_o,
    output logic [31:0]         wb_dat_o,
    output logic [3:0]          wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rd_buf_q, rd_buf_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          stb_q, stb_d;
    logic          cyc_q, cyc_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_buf_d  = rd_buf_q;
        bus_err_d = 1'b0;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        stb_d     = stb_q;
        cyc_d     = cyc_q;

        case (state_q)
            BUS_IDLE: begin
                if (cpu_ce_i == ChipEnable && !flush_i) begin
                    adr_d    = cpu_addr_i;
                    dat_d    = cpu_data_i;
                    sel_d    = cpu_sel_i;
                    we_d     = cpu_we_i;
                    stb_d    = 1'b1;
                    cyc_d    = 1'b1;
                    cnt_d    = '0;
                    rd_buf_d = '0;
                    state_d  = BUS_BUSY;
                end
            end
            BUS_BUSY: begin
                // Any way out of BUSY releases the bus; flush wins over a same-cycle ack.
                if (flush_i || wb_ack_i || cnt_q == CNT_LAST) begin
                    adr_d = '0;
                    dat_d = '0;
                    sel_d = '0;
                    we_d  = 1'b0;
                    stb_d = 1'b0;
                    cyc_d = 1'b0;
                end
                if (flush_i) begin
                    state_d = BUS_IDLE;
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = (stall_i != '0) ? BUS_WAIT_FOR_STALL : BUS_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    rd_buf_d  = '0;
                    state_d   = BUS_WAIT_FOR_STALL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUS_WAIT_FOR_STALL: begin
                if (stall_i == '0) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= BUS_IDLE;
            cnt_q     <= '0;
            rd_buf_q  <= '0;
            bus_err_q <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
        end
    end

    // Stall release and load data are combinational so a zero-wait slave costs one cycle.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_q)
            BUS_IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
            end
            BUS_BUSY: begin
                stallreq_o = !wb_ack_i && !flush_i;
                if (wb_ack_i && !we_q) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            BUS_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: ;
        endcase
    end

    assign bus_err_o = bus_err_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_data_bus_if.sv
// Directed and randomized transactions against data_bus_if, checked per cycle
// against expectations derived from each transaction's parameters.
module tb_data_bus_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int errors = 0;
    int checks = 0;

    data_bus_if #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Bus released and no stall request: what an idle bus master looks like.
    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, ".cyc"}, wb_cyc_o, 0);
        chk({tag, ".stb"}, wb_stb_o, 0);
        chk({tag, ".adr"}, wb_adr_o, 0);
        chk({tag, ".we"}, wb_we_o, 0);
        chk({tag, ".stallreq"}, stallreq_o, 0);
        chk({tag, ".cpu_data"}, cpu_data_o, 0);
        chk({tag, ".bus_err"}, bus_err_o, 0);
        next_cycle();
    endtask

    // One transaction: waits<0 means the slave never acks; nstall = WAIT cycles
    // after ack; flush_at = BUSY cycle index carrying flush_i (or -1).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, input int nstall, input int flush_at,
                           input logic [5:0] sv);
        int last;
        int k;
        bit done;
        bit flushed;
        logic exp_stall;
        logic [31:0] exp_data;
        last = (waits < 0) ? TO - 1 : waits;
        flushed = 1'b0;
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel;
        cpu_data_i = wdata; flush_i = 1'b0; stall_i = '0; wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        @(negedge clk);
        chk("req.stallreq", stallreq_o, 1);
        chk("req.cyc", wb_cyc_o, 0);
        chk("req.cpu_data", cpu_data_o, 0);
        next_cycle();
        k = 0;
        done = 1'b0;
        while (!done) begin
            wb_ack_i = (k == waits);
            wb_dat_i = wb_ack_i ? rdata : $urandom;
            flush_i  = (k == flush_at);
            stall_i  = (wb_ack_i && nstall > 0) ? sv : 6'd0;
            exp_stall = !wb_ack_i && !flush_i;
            exp_data  = (wb_ack_i && !we) ? rdata : 32'd0;
            @(negedge clk);
            chk("busy.cyc", wb_cyc_o, 1);
            chk("busy.stb", wb_stb_o, 1);
            chk("busy.adr", wb_adr_o, addr);
            chk("busy.dat", wb_dat_o, wdata);
            chk("busy.sel", wb_sel_o, sel);
            chk("busy.we", wb_we_o, we);
            chk("busy.stallreq", stallreq_o, exp_stall);
            chk("busy.cpu_data", cpu_data_o, exp_data);
            chk("busy.bus_err", bus_err_o, 0);
            next_cycle();
            flushed = flush_i;
            done = flush_i || wb_ack_i || (k == last);
            k++;
        end
        cpu_ce_i = 1'b0; wb_ack_i = 1'b0; flush_i = 1'b0;
        if (!flushed && waits < 0) begin
            stall_i = '0;
            @(negedge clk);
            chk("tmo.bus_err", bus_err_o, 1);
            chk("tmo.cyc", wb_cyc_o, 0);
            chk("tmo.stb", wb_stb_o, 0);
            chk("tmo.stallreq", stallreq_o, 0);
            chk("tmo.cpu_data", cpu_data_o, 0);
            next_cycle();
        end else if (!flushed) begin
            for (int j = 0; j < nstall; j++) begin
                stall_i  = (j < nstall - 1) ? sv : 6'd0;
                wb_dat_i = $urandom;
                @(negedge clk);
                chk("wait.cyc", wb_cyc_o, 0);
                chk("wait.stallreq", stallreq_o, 0);
                chk("wait.cpu_data", cpu_data_o, we ? 32'd0 : rdata);
                chk("wait.bus_err", bus_err_o, 0);
                next_cycle();
            end
        end
        stall_i = '0;
        chk_idle("after");
    endtask

    initial begin
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        chk_idle("reset");

        // Zero-wait read
        run_txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, 6'd0);
        // Store with 3-wait slave
        run_txn(1'b1, 32'h0000_0200, 4'b0011, 32'h1234_1234, 32'hFFFF_FFFF, 3, 0, -1, 6'd0);
        // Read acked while the pipeline stays stalled 3 more cycles
        run_txn(1'b0, 32'h0000_0304, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 3, -1, 6'b001111);
        // Flush on 2nd BUSY cycle together with ack
        run_txn(1'b0, 32'h0000_0408, 4'hF, 32'h0, 32'hA5A5_5A5A, 1, 0, 1, 6'd0);
        // Slave never acks
        run_txn(1'b0, 32'h0000_050C, 4'hF, 32'h0, 32'h1111_2222, -1, 0, -1, 6'd0);

        // Request with simultaneous flush must not start
        cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h0000_0600;
        @(negedge clk);
        chk("ceflush.stallreq", stallreq_o, 0);
        next_cycle();
        cpu_ce_i = 1'b0; flush_i = 1'b0;
        chk_idle("ceflush");

        // Reset while BUSY
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0700; cpu_sel_i = 4'hF;
        next_cycle();
        @(negedge clk);
        chk("rstbusy.cyc_before", wb_cyc_o, 1);
        next_cycle();
        cpu_ce_i = 1'b0; rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk_idle("rstbusy");
        run_txn(1'b0, 32'h0000_0704, 4'hF, 32'h0, 32'h7777_8888, 2, 1, -1, 6'b100000);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            int w;
            int fa;
            logic [5:0] sv;
            w  = int'($urandom_range(0, 4));
            if (w == 4) w = -1;
            fa = -1;
            if ($urandom_range(0, 5) == 0) fa = int'($urandom_range(0, (w < 0) ? TO - 1 : w));
            sv = 6'($urandom_range(1, 63));
            run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
                    w, int'($urandom_range(0, 3)), fa, sv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_bus_if.md
# data_bus_if

Data-side bus master placed directly downstream of the memory-access stage. It converts the stage's single-cycle combinational RAM request into a multi-cycle Wishbone classic transaction. It raises a stall request to the pipeline controller while the transaction is outstanding, and it holds load data stable until the pipeline resumes. A watchdog aborts transactions that receive no acknowledge.

## Interface
- `TIMEOUT`, default 255: number of `BUSY` cycles without `wb_ack_i` before the transaction is aborted. Must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; synchronous, active-high (`RstEnable` = 1'b1).
- `stall_i`  in  6  pipeline stall vector from the controller; any nonzero bit means the pipeline is held.
- `flush_i`  in  1  exception flush from the controller.
- `cpu_ce_i`  in  1  request valid from the memory stage (`mem_ce_o`).
- `cpu_we_i`  in  1  write request (`mem_we_o`, already exception-masked).
- `cpu_addr_i`  in  32  byte address.
- `cpu_sel_i`  in  4  byte enables; bit 3 = bits 31:24 (big-endian lanes).
- `cpu_data_i`  in  32  store data, already lane-replicated.
- `cpu_data_o`  out  32  load data returned to the memory stage.
- `stallreq_o`  out  1  stall request to the controller.
- `bus_err_o`  out  1  one-cycle pulse on timeout abort.
- `wb_adr_o`  out  32; `wb_dat_o`  out  32; `wb_sel_o`  out  4; `wb_we_o`  out  1; `wb_stb_o`  out  1; `wb_cyc_o`  out  1: master outputs, all registered.
- `wb_dat_i`  in  32; `wb_ack_i`  in  1: slave response.

## Operation
- States: `IDLE`, `BUSY`, `WAIT_FOR_STALL`.
- In `IDLE`, if `cpu_ce_i && !flush_i`, latch the address, data, sel and we onto the wb outputs, set `stb`/`cyc`, clear the timeout counter, clear `rd_buf`, and go to `BUSY`.
- In `BUSY`, if `flush_i` is set, drop every wb output to 0 and go to `IDLE`. The flush takes priority over `wb_ack_i`.
- In `BUSY`, if `wb_ack_i` is set, drop every wb output to 0. For a read, capture `rd_buf <= wb_dat_i`. Then go to `WAIT_FOR_STALL` if `stall_i != 0`, otherwise to `IDLE`.
- In `BUSY`, if the counter reaches `TIMEOUT-1` with no ack, drop the wb outputs, pulse `bus_err_o`, set `rd_buf <= 0`, and go to `WAIT_FOR_STALL`. Otherwise increment the counter.
- In `WAIT_FOR_STALL`, return to `IDLE` once `stall_i == 0`.
- `stallreq_o` and `cpu_data_o` are combinational:
  - `IDLE`: `stallreq_o = cpu_ce_i && !flush_i`; `cpu_data_o = 0`.
  - `BUSY`: `stallreq_o = !wb_ack_i && !flush_i`. `cpu_data_o` is `wb_dat_i` on an acked read, otherwise 0.
  - `WAIT_FOR_STALL`: `stallreq_o = 0`; `cpu_data_o = rd_buf`.
- `wb_sel_o`, `wb_adr_o` and `wb_dat_o` are passed through unmodified; lane steering stays in the memory stage.
- The counter is ⌈log2(TIMEOUT+1)⌉ bits wide and never wraps, because it is cleared on entry to `BUSY`.

## Timing
- All outputs reset to 0: wb outputs, `rd_buf`, counter and `bus_err_o`. State resets to `IDLE`.
- Reset asserted mid-transaction: on the next edge `cyc` and `stb` drop to 0 and state is `IDLE`. The slave must tolerate the abandoned cycle.
- Minimum latency with a zero-wait slave:
  - Cycle 0: request seen and stall asserted.
  - Cycle 1: `BUSY` with ack; stall deasserts combinationally and data is valid.
  - The memory stage therefore sees the result 1 cycle after request.
- The wb outputs are stable for the whole of `BUSY`; `stb` is never reasserted without passing through `IDLE`.
- Back-to-back requests: a new request is accepted in the first `IDLE` cycle, i.e. at least one idle cycle between transactions.
- Simultaneous `flush_i` and `cpu_ce_i` in `IDLE`: no transaction starts.

## Structure
- State encodings (2-bit `BUS_IDLE`/`BUS_BUSY`/`BUS_WAIT_FOR_STALL`) and the stall-vector width go in `defines.v`, next to `RstEnable` and `ChipEnable`.
- The block is one module with no sub-module. Instruction-side reuse is by instantiating a second copy.

## Test plan
- Zero-wait read of `0x0000_0100` with slave data `0xDEAD_BEEF`:
  - `stallreq_o` is 1 for exactly one cycle.
  - `cpu_data_o == 0xDEADBEEF` in the ack cycle.
  - `cyc` drops the next cycle.
- Store `sel=4'b0011`, data `0x1234_1234`, with a 3-wait slave: `wb_sel_o`, `wb_dat_o` and `wb_we_o=1` are held for 4 cycles, and `cpu_data_o` stays 0 throughout.
- Read acked while `stall_i = 6'b001111` is held 3 more cycles: the state is `WAIT_FOR_STALL` and `cpu_data_o` holds the captured word for all 3 cycles, then returns to 0 in `IDLE`.
- `flush_i` asserted on the 2nd `BUSY` cycle of a read with ack arriving in the same cycle: `cyc`/`stb` drop, `rd_buf` stays 0, state is `IDLE`, and `stallreq_o` is 0 in that cycle.
- Slave never acks with `TIMEOUT=4`: `bus_err_o` pulses once after 4 `BUSY` cycles, `cyc` drops, and `cpu_data_o = 0`.
- `rst` asserted during `BUSY`: all wb outputs are 0 on the next edge, and a new request after reset completes normally.
